// File: rtl/layer_output_serializer_if.sv
// Word stream from a layer serializer into the next layer's neuron input port.
interface layer_output_serializer_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic                  i_data_ready;
  logic                  o_last;

  modport master (output o_data, output o_data_valid, output o_last, input i_data_ready);
  modport slave  (input o_data, input o_data_valid, input o_last, output i_data_ready);
endinterface

// File: rtl/layer_output_serializer.sv
// Collects one layer's parallel neuron results into a frame, then streams them in index order.
// Optional SERIALIZER_ARGMAX_EN adds a running signed argmax over the streamed frame.
module layer_output_serializer #(
  parameter int unsigned LAYER_ID   = 1,
  parameter int unsigned NUM_NEURON = 30,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] i_neuron_output,
  input  logic [NUM_NEURON-1:0]            i_neuron_valid,
  layer_output_serializer_if.master        stream,
  output logic                             o_frame_done,
  output logic                             o_busy,
  output logic                             o_overrun
`ifdef SERIALIZER_ARGMAX_EN
  ,
  output logic [$clog2(NUM_NEURON)-1:0]    o_max_index,
  output logic                             o_max_valid
`endif
);

  localparam int unsigned IDX_W    = $clog2(NUM_NEURON);
  localparam int unsigned LAST_IDX = NUM_NEURON - 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_IDX);

  typedef enum logic [1:0] {COLLECT, STREAM, DONE} state_e;

  state_e                  state_q, state_d;
  logic [NUM_NEURON-1:0]   mask_q, mask_d;
  logic [NUM_NEURON-1:0]   cap_c;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  logic                    xfer_c;
  logic [DATA_WIDTH-1:0]   buf_q [NUM_NEURON];

`ifdef SERIALIZER_ARGMAX_EN
  logic [DATA_WIDTH-1:0]   max_q, max_d;
  logic [IDX_W-1:0]        max_idx_q, max_idx_d;
  logic                    max_valid_q, max_valid_d;
`endif

  assign xfer_c = valid_q && stream.i_data_ready;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    cap_c     = '0;
    unique case (state_q)
      COLLECT: begin
        cap_c  = i_neuron_valid & ~mask_q;
        mask_d = mask_q | i_neuron_valid;
        if ((i_neuron_valid & mask_q) != '0) overrun_d = 1'b1;
        if (&mask_d) begin
          // word 0 may be captured on this very edge, so bypass the buffer
          state_d = STREAM;
          valid_d = 1'b1;
          idx_d   = '0;
          last_d  = 1'b0;
          data_d  = cap_c[0] ? i_neuron_output[DATA_WIDTH-1:0] : buf_q[0];
        end
      end
      STREAM: begin
        if (i_neuron_valid != '0) overrun_d = 1'b1;
        if (xfer_c) begin
          if (idx_q == LAST) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            mask_d  = '0;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = buf_q[idx_d];
            last_d = (idx_d == LAST);
          end
        end
      end
      DONE: begin
        if (i_neuron_valid != '0) overrun_d = 1'b1;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    busy_d = (state_d != COLLECT);

`ifdef SERIALIZER_ARGMAX_EN
    max_d       = max_q;
    max_idx_d   = max_idx_q;
    max_valid_d = 1'b0;
    // strict compare keeps the lowest index on ties
    if (state_q == STREAM && xfer_c) begin
      if (idx_q == '0 || $signed(data_q) > $signed(max_q)) begin
        max_d     = data_q;
        max_idx_d = idx_q;
      end
      if (idx_q == LAST) max_valid_d = 1'b1;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q   <= COLLECT;
      mask_q    <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // Frame buffer needs no reset; only captured entries are ever streamed
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_NEURON; k++) begin
      if (cap_c[k]) buf_q[k] <= i_neuron_output[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset && state_q == STREAM) begin
      assert (idx_q <= LAST) else $error("serializer L%0d: stream index out of range", LAYER_ID);
    end
  end

`ifdef SERIALIZER_ARGMAX_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      max_q       <= '0;
      max_idx_q   <= '0;
      max_valid_q <= 1'b0;
    end else begin
      max_q       <= max_d;
      max_idx_q   <= max_idx_d;
      max_valid_q <= max_valid_d;
    end
  end

  assign o_max_index = max_idx_q;
  assign o_max_valid = max_valid_q;
`endif

  assign stream.o_data       = data_q;
  assign stream.o_data_valid = valid_q;
  assign stream.o_last       = last_q;
  assign o_frame_done        = done_q;
  assign o_busy              = busy_q;
  assign o_overrun           = overrun_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer: directed and randomized frames against a frame-level model.
module tb_layer_output_serializer;

  localparam int unsigned NN = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [NN*DW-1:0]   n_out;
  logic [NN-1:0]      n_valid;
  logic               frame_done, busy, overrun;
`ifdef SERIALIZER_ARGMAX_EN
  logic [IW-1:0]      max_index;
  logic               max_valid;
`endif

  layer_output_serializer_if #(.DATA_WIDTH(DW)) s_if ();

  layer_output_serializer #(.LAYER_ID(1), .NUM_NEURON(NN), .DATA_WIDTH(DW)) dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_neuron_output (n_out),
    .i_neuron_valid  (n_valid),
    .stream          (s_if),
    .o_frame_done    (frame_done),
    .o_busy          (busy),
    .o_overrun       (overrun)
`ifdef SERIALIZER_ARGMAX_EN
    ,
    .o_max_index     (max_index),
    .o_max_valid     (max_valid)
`endif
  );

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Frame model: captured words in index order plus the sticky overrun flag
  logic [DW-1:0] exp_w      [NN];
  logic [DW-1:0] frame_vals [NN];
  logic [NN-1:0] m_mask;
  bit            m_ovr;
  logic [DW-1:0] dup_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NN*DW-1:0] rand_bus();
    logic [NN*DW-1:0] b;
    for (int k = 0; k < NN; k++) b[k*DW +: DW] = DW'($urandom);
    return b;
  endfunction

  task automatic cap_cycle(input logic [NN-1:0] vm, input logic [NN*DW-1:0] bus);
    n_valid = vm;
    n_out   = bus;
    tick();
    for (int k = 0; k < NN; k++) begin
      if (vm[k]) begin
        if (m_mask[k]) m_ovr = 1'b1;
        else begin
          m_mask[k] = 1'b1;
          exp_w[k]  = bus[k*DW +: DW];
        end
      end
    end
    n_valid = '0;
    if (&m_mask) begin
      chk("start_valid", 32'(s_if.o_data_valid), 32'(1));
      chk("start_data",  32'(s_if.o_data), 32'(exp_w[0]));
      chk("start_busy",  32'(busy), 32'(1));
      chk("start_last",  32'(s_if.o_last), 32'(0));
    end else begin
      chk("collect_valid", 32'(s_if.o_data_valid), 32'(0));
      chk("collect_busy",  32'(busy), 32'(0));
    end
  endtask

  // mode 0: one neuron per cycle in order; 1: all at once; other: random subsets
  task automatic run_frame(input int mode, input bit dup_en, input bit inject_en,
                           input int ready_pct, input int stall_at);
    logic [NN*DW-1:0] bus;
    logic [NN-1:0]    vm;
    int guard, idx, cyc, stalls, best;
    bit rdy;
    m_mask = '0;
    if (mode == 0) begin
      for (int k = 0; k < NN; k++) begin
        bus = rand_bus();
        bus[k*DW +: DW] = frame_vals[k];
        cap_cycle(NN'(1) << k, bus);
        if (dup_en && k == 2) begin
          bus = rand_bus();
          bus[2*DW +: DW] = dup_val;
          cap_cycle(NN'(4), bus);
        end
      end
    end else if (mode == 1) begin
      for (int k = 0; k < NN; k++) bus[k*DW +: DW] = frame_vals[k];
      cap_cycle('1, bus);
    end else begin
      guard = 0;
      while (!(&m_mask) && guard < 64) begin
        bus = rand_bus();
        vm  = NN'($urandom) & ~m_mask;
        if (dup_en && $urandom_range(0, 3) == 0) vm = vm | (NN'($urandom) & m_mask);
        for (int k = 0; k < NN; k++) if (!m_mask[k]) bus[k*DW +: DW] = frame_vals[k];
        cap_cycle(vm, bus);
        guard++;
      end
      chk("collect_complete", 32'(&m_mask), 32'(1));
    end

    idx = 0; cyc = 0; stalls = 0;
    while (idx < NN && cyc < 200) begin
      if (idx == stall_at && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
      end else begin
        rdy = ($urandom_range(0, 99) < ready_pct);
      end
      s_if.i_data_ready = rdy;
      if (inject_en && $urandom_range(0, 3) == 0) begin
        n_valid = NN'($urandom) | NN'(1);
        m_ovr   = 1'b1;
      end
      chk("stream_valid", 32'(s_if.o_data_valid), 32'(1));
      chk("stream_data",  32'(s_if.o_data), 32'(exp_w[idx]));
      chk("stream_last",  32'(s_if.o_last), 32'(idx == NN - 1));
      tick();
      n_valid = '0;
      if (rdy) idx++;
      cyc++;
    end
    chk("xfer_count", 32'(idx), 32'(NN));
    s_if.i_data_ready = 1'b1;

    chk("done_pulse",   32'(frame_done), 32'(1));
    chk("done_valid",   32'(s_if.o_data_valid), 32'(0));
    chk("done_busy",    32'(busy), 32'(1));
    chk("done_last",    32'(s_if.o_last), 32'(0));
    chk("done_overrun", 32'(overrun), 32'(m_ovr));
`ifdef SERIALIZER_ARGMAX_EN
    best = 0;
    for (int k = 1; k < NN; k++) if ($signed(exp_w[k]) > $signed(exp_w[best])) best = k;
    chk("max_valid", 32'(max_valid), 32'(1));
    chk("max_index", 32'(max_index), 32'(best));
`else
    best = 0;
`endif
    tick();
    chk("post_done_pulse", 32'(frame_done), 32'(0));
    chk("post_done_busy",  32'(busy), 32'(0));
    chk("post_done_valid", 32'(s_if.o_data_valid), 32'(0));
`ifdef SERIALIZER_ARGMAX_EN
    chk("post_max_valid",  32'(max_valid), 32'(0));
`endif
  endtask

  initial begin
    logic [NN*DW-1:0] bus;
    rst_n = 1'b0;
    n_valid = '0;
    n_out = '0;
    s_if.i_data_ready = 1'b0;
    m_ovr = 1'b0;
    dup_val = '0;
    tick();
    tick();
    chk("rst_valid",   32'(s_if.o_data_valid), 32'(0));
    chk("rst_data",    32'(s_if.o_data), 32'(0));
    chk("rst_last",    32'(s_if.o_last), 32'(0));
    chk("rst_done",    32'(frame_done), 32'(0));
    chk("rst_busy",    32'(busy), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
`ifdef SERIALIZER_ARGMAX_EN
    chk("rst_max_index", 32'(max_index), 32'(0));
    chk("rst_max_valid", 32'(max_valid), 32'(0));
`endif
    rst_n = 1'b1;
    tick();

    // basic frame, one capture per cycle, ready held high
    frame_vals[0] = 16'h0010; frame_vals[1] = 16'h0020;
    frame_vals[2] = 16'h0030; frame_vals[3] = 16'h0040;
    run_frame(0, 1'b0, 1'b0, 100, -1);

    // same frame, ready low for 3 cycles while word 1 is presented
    run_frame(0, 1'b0, 1'b0, 100, 1);

    // all four captured on one edge, including a negative word
    frame_vals[0] = 16'h0001; frame_vals[1] = 16'hFFFF;
    frame_vals[2] = 16'h0005; frame_vals[3] = 16'h0002;
    run_frame(1, 1'b0, 1'b0, 100, -1);

    // neuron 2 pulses 7 then 9; first capture wins, overrun becomes sticky
    frame_vals[0] = 16'h0011; frame_vals[1] = 16'h0022;
    frame_vals[2] = 16'h0007; frame_vals[3] = 16'h0044;
    dup_val = 16'h0009;
    run_frame(0, 1'b1, 1'b1, 100, -1);

    // randomized frames with random backpressure, duplicates and stray valids
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < NN; k++) frame_vals[k] = DW'($urandom);
      run_frame(2, 1'($urandom), 1'($urandom), 40 + int'($urandom_range(0, 60)),
                int'($urandom_range(0, NN)) - 1);
    end

    // reset after word 1 transfers: stream drops, no frame_done
    for (int k = 0; k < NN; k++) frame_vals[k] = DW'($urandom);
    m_mask = '0;
    for (int k = 0; k < NN; k++) bus[k*DW +: DW] = frame_vals[k];
    cap_cycle('1, bus);
    s_if.i_data_ready = 1'b1;
    tick();
    tick();
    chk("mid_data",  32'(s_if.o_data), 32'(exp_w[2]));
    chk("mid_valid", 32'(s_if.o_data_valid), 32'(1));
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid",   32'(s_if.o_data_valid), 32'(0));
    chk("mid_rst_done",    32'(frame_done), 32'(0));
    chk("mid_rst_busy",    32'(busy), 32'(0));
    chk("mid_rst_overrun", 32'(overrun), 32'(0));
    m_ovr = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_done",  32'(frame_done), 32'(0));
    chk("post_rst_valid", 32'(s_if.o_data_valid), 32'(0));
    for (int k = 0; k < NN; k++) frame_vals[k] = DW'($urandom);
    run_frame(2, 1'b0, 1'b0, 100, -1);
    for (int k = 0; k < NN; k++) frame_vals[k] = DW'($urandom);
    run_frame(2, 1'b1, 1'b1, 70, 2);

`ifdef SERIALIZER_ARGMAX_EN
    // tie between words 2 and 3 resolves to the lower index
    frame_vals[0] = 16'h0003; frame_vals[1] = 16'hFFF8;
    frame_vals[2] = 16'h0009; frame_vals[3] = 16'h0009;
    run_frame(0, 1'b0, 1'b0, 100, -1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/layer_output_serializer.md
Name: layer_output_serializer

Overview:
- Transmitter side of the neuron input stream.
- Captures the parallel results (output, valid) of all NUM_NEURON neurons of one layer into a frame buffer.
- Once the frame is complete, streams the results one word at a time, in neuron-index order, over a valid/ready handshake into the next layer's neuron input port (i_input / i_input_valid / o_input_ready).
- One instance sits between every pair of consecutive layers in the network top.

Parameters:
- LAYER_ID, 1: source layer index; used only for display and debug.
- NUM_NEURON, 30: neurons in the source layer; equals the next layer's NUM_WEIGHT. Range 2..1024.
- DATA_WIDTH, 16: width of one neuron result; two's complement fixed point.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_neuron_output  in  NUM_NEURON*DATA_WIDTH  neuron results; neuron k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_neuron_valid  in  NUM_NEURON  per-neuron one-cycle valid pulses.
- o_data  out  DATA_WIDTH  streamed word; connects to the next layer's i_input.
- o_data_valid  out  1  o_data holds a word; connects to i_input_valid.
- i_data_ready  in  1  sink accepts a word; AND of all next-layer o_input_ready.
- o_last  out  1  high together with o_data_valid on word NUM_NEURON-1.
- o_frame_done  out  1  one-cycle pulse after the last word transfers.
- o_busy  out  1  high while in STREAM or DONE.
- o_overrun  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (i_reset==0 at a rising edge):
  - State goes to COLLECT; capture mask and stream index are cleared.
  - o_data=0, o_data_valid=0, o_last=0, o_frame_done=0, o_busy=0, o_overrun=0.
  - Buffer contents are don't-care.
  - A reset in mid-stream drops o_data_valid on that same edge. The partial frame is discarded, and no o_frame_done is issued.
- State COLLECT:
  - Neuron k with i_neuron_valid[k]=1 and mask[k]=0: its word is stored in buf[k] and mask[k] is set.
  - Neuron k with i_neuron_valid[k]=1 and mask[k]=1: the word is ignored (first capture wins) and o_overrun is set.
  - Any number of valid bits may be high in the same cycle; all are processed independently.
  - If the mask becomes all-ones on edge N (counting captures made on that edge), the block enters STREAM on edge N. In cycle N+1: o_data_valid=1, o_data=buf[0], o_busy=1.
- State STREAM:
  - A word transfers on a rising edge where o_data_valid && i_data_ready.
  - o_data and o_data_valid are held stable until the transfer. i_data_ready may toggle freely.
  - On a transfer, the index increments and o_data=buf[index+1] from the next cycle, so sustained throughput is 1 word/cycle when ready is held high.
  - o_last = (index==NUM_NEURON-1) && o_data_valid.
  - On transfer of the last word: the block enters DONE, o_data_valid drops, the mask and index clear.
  - Any i_neuron_valid bit seen in STREAM or DONE is dropped and sets o_overrun. It does not affect the frame.
- State DONE (one cycle):
  - o_frame_done=1, o_busy=1; then the block returns to COLLECT.
  - o_frame_done is high exactly one cycle per frame.
- Minimum frame period = 1 (collect edge) + NUM_NEURON (stream) + 1 (DONE) cycles.
- Index counter width = clog2(NUM_NEURON); it is never compared beyond NUM_NEURON-1.

Optional Feature:
- Macro: SERIALIZER_ARGMAX_EN.
- When defined:
  - Adds outputs o_max_index (clog2(NUM_NEURON) bits) and o_max_valid (1 bit).
  - During STREAM, each transferred word is compared signed against the running max. A strictly greater word updates the max and its index, so the lowest index wins ties. Word 0 initialises the max.
  - o_max_index is registered; o_max_valid pulses together with o_frame_done. Both are 0 on reset.
  - Used on the final layer for classification.
- When not defined: the ports and compare logic are absent; all other behaviour is identical.

Test Plan:
- Basic frame: NUM_NEURON=4, DATA_WIDTH=16, pulse valids one per cycle with values 0x0010,0x0020,0x0030,0x0040, i_data_ready=1 -> o_data 0x0010..0x0040 on 4 consecutive cycles starting the cycle after the 4th capture; o_last only on 0x0040; o_frame_done one cycle later; o_overrun=0.
- Backpressure: same frame, i_data_ready low 3 cycles after word 1 -> o_data=0x0020 with o_data_valid=1 held 3 extra cycles; no word lost or duplicated; 4 transfers total.
- Simultaneous capture: all 4 valid bits in one cycle with 1,-1,5,2 -> STREAM next cycle, words in index order 1,0xFFFF,5,2.
- Overrun: neuron 2 valid twice in COLLECT (7 then 9), then a valid during STREAM -> buf[2]=7 streamed, o_overrun=1 and stays 1 until reset.
- Reset mid-stream: assert i_reset=0 after word 1 transfers -> o_data_valid=0 on that edge, no o_frame_done; after release, a new full frame streams correctly from index 0.
- ARGMAX (SERIALIZER_ARGMAX_EN): words 3,-8,9,9 -> o_max_index=2, o_max_valid high together with o_frame_done.
